mem_port_arbiter: RTL and testbench

Arbiter that shares the single unified memory port of the multi-cycle CPU between its instruction-fetch channel (IF state) and its data channel (MEM state, loads and stores). Each channel uses a valid/ready request and response handshake. The arbiter serialises them so that at most one memory transaction is outstanding, grants round-robin on contention, and routes each response back to the channel that issued it. Grant counters are exposed for performance tracing.

---
 rtl/mem_port_arbiter.sv | 138 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Shares the unified memory port between the fetch and data channels.
// One outstanding transaction at a time, round-robin on contention.
module mem_port_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                inst_req_valid,
    output logic                inst_req_ready,
    input  logic [ADDR_W-1:0]   inst_addr,
    output logic                inst_resp_valid,
    input  logic                inst_resp_ready,
    output logic [DATA_W-1:0]   inst_rdata,
    input  logic                data_req_valid,
    output logic                data_req_ready,
    input  logic [ADDR_W-1:0]   data_addr,
    input  logic                data_wen,
    input  logic [DATA_W-1:0]   data_wdata,
    input  logic [DATA_W/8-1:0] data_wstrb,
    output logic                data_resp_valid,
    input  logic                data_resp_ready,
    output logic [DATA_W-1:0]   data_rdata,
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic                mem_wen,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wstrb,
    input  logic                mem_resp_valid,
    output logic                mem_resp_ready,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic [31:0]         inst_grant_cnt,
    output logic [31:0]         data_grant_cnt
);

    localparam int STRB_W = DATA_W / 8;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND,
        S_WAIT,
        S_RETURN
    } state_t;

    state_t              state_q;
    logic                prio_q;
    logic                owner_q;
    logic [ADDR_W-1:0]   addr_q;
    logic                wen_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [STRB_W-1:0]   wstrb_q;
    logic [DATA_W-1:0]   rdata_q;
    logic [31:0]         icnt_q;
    logic [31:0]         dcnt_q;

    logic idle;
    logic grant_inst;
    logic grant_data;
    logic owner_ready;

    // prio_q = 0 favours the fetch channel when both request
    assign idle       = (state_q == S_IDLE);
    assign grant_inst = idle && inst_req_valid
                        && (!data_req_valid || !prio_q);
    assign grant_data = idle && data_req_valid
                        && (!inst_req_valid || prio_q);
    assign owner_ready = owner_q ? data_resp_ready : inst_resp_ready;

    assign inst_req_ready  = rst && grant_inst;
    assign data_req_ready  = rst && grant_data;
    assign mem_req_valid   = rst && (state_q == S_SEND);
    assign mem_resp_ready  = rst && (state_q == S_WAIT);
    assign inst_resp_valid = rst && (state_q == S_RETURN) && !owner_q;
    assign data_resp_valid = rst && (state_q == S_RETURN) && owner_q;

    assign mem_addr       = addr_q;
    assign mem_wen        = wen_q;
    assign mem_wdata      = wdata_q;
    assign mem_wstrb      = wstrb_q;
    assign inst_rdata     = rdata_q;
    assign data_rdata     = rdata_q;
    assign inst_grant_cnt = icnt_q;
    assign data_grant_cnt = dcnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            prio_q  <= 1'b0;
            owner_q <= 1'b0;
            addr_q  <= '0;
            wen_q   <= 1'b0;
            wdata_q <= '0;
            wstrb_q <= '0;
            rdata_q <= '0;
            icnt_q  <= '0;
            dcnt_q  <= '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (grant_inst) begin
                        addr_q  <= inst_addr;
                        wen_q   <= 1'b0;
                        wdata_q <= '0;
                        wstrb_q <= '0;
                        owner_q <= 1'b0;
                        prio_q  <= 1'b1;
                        icnt_q  <= icnt_q + 32'd1;
                        state_q <= S_SEND;
                    end else if (grant_data) begin
                        addr_q  <= data_addr;
                        wen_q   <= data_wen;
                        wdata_q <= data_wdata;
                        wstrb_q <= data_wstrb;
                        owner_q <= 1'b1;
                        prio_q  <= 1'b0;
                        dcnt_q  <= dcnt_q + 32'd1;
                        state_q <= S_SEND;
                    end
                end
                S_SEND: begin
                    if (mem_req_ready) state_q <= S_WAIT;
                end
                S_WAIT: begin
                    if (mem_resp_valid) begin
                        rdata_q <= mem_rdata;
                        state_q <= S_RETURN;
                    end
                end
                S_RETURN: begin
                    if (owner_ready) state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: queue-based transaction model
// plus directed reset, contention and minimum-latency sequences.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        inst_req_valid = 1'b0;
    logic        inst_req_ready;
    logic [31:0] inst_addr = '0;
    logic        inst_resp_valid;
    logic        inst_resp_ready = 1'b0;
    logic [31:0] inst_rdata;
    logic        data_req_valid = 1'b0;
    logic        data_req_ready;
    logic [31:0] data_addr = '0;
    logic        data_wen = 1'b0;
    logic [31:0] data_wdata = '0;
    logic [3:0]  data_wstrb = '0;
    logic        data_resp_valid;
    logic        data_resp_ready = 1'b0;
    logic [31:0] data_rdata;
    logic        mem_req_valid;
    logic        mem_req_ready = 1'b0;
    logic [31:0] mem_addr;
    logic        mem_wen;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_resp_valid = 1'b0;
    logic        mem_resp_ready;
    logic [31:0] mem_rdata = '0;
    logic [31:0] inst_grant_cnt;
    logic [31:0] data_grant_cnt;

    mem_port_arbiter dut (
        .clk(clk), .rst(rst),
        .inst_req_valid(inst_req_valid), .inst_req_ready(inst_req_ready),
        .inst_addr(inst_addr), .inst_resp_valid(inst_resp_valid),
        .inst_resp_ready(inst_resp_ready), .inst_rdata(inst_rdata),
        .data_req_valid(data_req_valid), .data_req_ready(data_req_ready),
        .data_addr(data_addr), .data_wen(data_wen),
        .data_wdata(data_wdata), .data_wstrb(data_wstrb),
        .data_resp_valid(data_resp_valid),
        .data_resp_ready(data_resp_ready), .data_rdata(data_rdata),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_addr(mem_addr), .mem_wen(mem_wen), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_resp_valid(mem_resp_valid),
        .mem_resp_ready(mem_resp_ready), .mem_rdata(mem_rdata),
        .inst_grant_cnt(inst_grant_cnt), .data_grant_cnt(data_grant_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        ch;
        logic [31:0] addr;
        logic        wen;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } req_t;

    typedef struct {
        logic        ch;
        logic [31:0] data;
    } rsp_t;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;

    // granted-not-sent, sent-not-answered, answered-not-delivered
    req_t req_q[$];
    req_t mem_q[$];
    rsp_t rsp_q[$];
    logic        prio_m = 1'b0;
    logic [31:0] cnt_i = '0;
    logic [31:0] cnt_d = '0;

    function automatic void check(input string name,
                                  input logic [127:0] act,
                                  input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h @%0t", name, act, exp, $time);
        end
    endfunction

    function automatic int pending();
        return req_q.size() + mem_q.size() + rsp_q.size();
    endfunction

    logic busy, win_i, win_d, exp_mv, exp_mr, ri, rd;
    req_t r;
    rsp_t s;

    always @(negedge clk) begin
        if (!rst) begin
            check("rst_outputs",
                  {inst_req_ready, data_req_ready, mem_req_valid,
                   mem_resp_ready, inst_resp_valid, data_resp_valid}, 0);
            check("rst_counters", {inst_grant_cnt, data_grant_cnt}, 0);
            req_q.delete();
            mem_q.delete();
            rsp_q.delete();
            prio_m = 1'b0;
            cnt_i  = '0;
            cnt_d  = '0;
        end else begin
            busy  = pending() != 0;
            win_i = !busy && inst_req_valid && (!data_req_valid || !prio_m);
            win_d = !busy && data_req_valid && (!inst_req_valid || prio_m);
            check("req_ready", {inst_req_ready, data_req_ready},
                  {win_i, win_d});
            check("grant_cnt", {inst_grant_cnt, data_grant_cnt},
                  {cnt_i, cnt_d});
            exp_mv = req_q.size() != 0;
            check("mem_req_valid", mem_req_valid, exp_mv);
            if (exp_mv && mem_req_valid) begin
                r = req_q[0];
                check("mem_fields",
                      {mem_addr, mem_wen, mem_wdata, mem_wstrb},
                      {r.addr, r.wen, r.wdata, r.wstrb});
            end
            exp_mr = mem_q.size() != 0;
            check("mem_resp_ready", mem_resp_ready, exp_mr);
            ri = rsp_q.size() != 0 && rsp_q[0].ch == 1'b0;
            rd = rsp_q.size() != 0 && rsp_q[0].ch == 1'b1;
            check("resp_valid", {inst_resp_valid, data_resp_valid}, {ri, rd});
            if (ri) check("inst_rdata", inst_rdata, rsp_q[0].data);
            if (rd) check("data_rdata", data_rdata, rsp_q[0].data);

            if ((ri && inst_resp_ready) || (rd && data_resp_ready)) begin
                void'(rsp_q.pop_front());
                done_cnt++;
            end
            if (exp_mr && mem_resp_valid) begin
                s.ch   = mem_q[0].ch;
                s.data = mem_rdata;
                rsp_q.push_back(s);
                void'(mem_q.pop_front());
            end
            if (exp_mv && mem_req_ready) mem_q.push_back(req_q.pop_front());
            if (win_i) begin
                r.ch = 1'b0; r.addr = inst_addr; r.wen = 1'b0;
                r.wdata = '0; r.wstrb = '0;
                req_q.push_back(r);
                cnt_i  = cnt_i + 32'd1;
                prio_m = 1'b1;
            end else if (win_d) begin
                r.ch = 1'b1; r.addr = data_addr; r.wen = data_wen;
                r.wdata = data_wdata; r.wstrb = data_wstrb;
                req_q.push_back(r);
                cnt_d  = cnt_d + 32'd1;
                prio_m = 1'b0;
            end
        end
    end

    task automatic drain();
        @(posedge clk); #1;
        inst_req_valid = 0; data_req_valid = 0;
        mem_req_ready = 1; mem_resp_valid = 1;
        inst_resp_ready = 1; data_resp_ready = 1;
        for (int c = 0; c < 100 && pending() != 0; c++) begin
            @(negedge clk); #1;
        end
        check("drain_timeout", pending(), 0);
    endtask

    task automatic run_fetch(input logic [31:0] a, input logic [31:0] d);
        drain();
        @(posedge clk); #1;
        inst_addr = a; inst_req_valid = 1; data_req_valid = 0;
        mem_req_ready = 1; mem_resp_valid = 1; mem_rdata = d;
        @(negedge clk);
        check("fetch_c0_ready", inst_req_ready, 1);
        @(posedge clk); #1;
        inst_req_valid = 0;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            check("fetch_phase",
                  {mem_req_valid, mem_resp_ready, inst_resp_valid},
                  3'b100 >> (c - 1));
            if (c == 1)
                check("fetch_mem_fields", {mem_addr, mem_wen, mem_wstrb},
                      {a, 1'b0, 4'h0});
            if (c == 3) check("fetch_rdata", inst_rdata, d);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic order[$];
        logic reached;
        int   done0;

        // reset with both channels requesting
        inst_addr = 32'h200; inst_req_valid = 1;
        data_addr = 32'h1000; data_wen = 1;
        data_wdata = 32'hDEADBEEF; data_wstrb = 4'hF; data_req_valid = 1;
        mem_req_ready = 1; mem_resp_valid = 1; mem_rdata = 32'h5A5A0001;
        inst_resp_ready = 1; data_resp_ready = 1;
        repeat (3) @(posedge clk);
        #1 rst = 1;

        for (int c = 0; c < 40 && order.size() < 4; c++) begin
            @(negedge clk);
            if (inst_req_ready) order.push_back(1'b0);
            if (data_req_ready) order.push_back(1'b1);
        end
        check("contention_grants", order.size(), 4);
        foreach (order[i]) check("grant_order", order[i], i % 2);
        drain();
        check("cnt_2_2", {inst_grant_cnt, data_grant_cnt},
              {32'd2, 32'd2});

        run_fetch(32'h0000_0100, 32'h2402_000A);
        drain();

        done0 = done_cnt;
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            inst_req_valid  = ($urandom % 3) != 0;
            inst_addr       = $urandom;
            data_req_valid  = ($urandom % 3) != 0;
            data_addr       = $urandom & 32'hFFFF_FFFC;
            data_wen        = 1'($urandom);
            data_wdata      = $urandom;
            data_wstrb      = 4'($urandom);
            mem_req_ready   = ($urandom % 4) != 0;
            mem_resp_valid  = ($urandom % 3) != 0;
            mem_rdata       = $urandom;
            inst_resp_ready = ($urandom % 3) != 0;
            data_resp_ready = ($urandom % 3) != 0;
        end
        drain();
        check("random_liveness", (done_cnt - done0) >= 100, 1);

        // reset while awaiting the memory response
        @(posedge clk); #1;
        inst_addr = 32'h400; inst_req_valid = 1; mem_resp_valid = 0;
        @(posedge clk); #1;
        inst_req_valid = 0;
        reached = 0;
        for (int c = 0; c < 20 && !reached; c++) begin
            @(negedge clk);
            reached = mem_resp_ready;
        end
        check("wait_reached", reached, 1);
        #2 rst = 0; mem_resp_valid = 1; mem_rdata = 32'hBAD0BAD0;
        #1 check("rst_async_outputs",
                 {inst_req_ready, data_req_ready, mem_req_valid,
                  mem_resp_ready, inst_resp_valid, data_resp_valid}, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1;
        repeat (4) begin
            @(negedge clk);
            check("no_resp_after_rst", {inst_resp_valid, data_resp_valid}, 0);
        end
        run_fetch(32'h0000_0500, 32'h0BAD_F00D);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
